therm_sample_ctrl: RTL and testbench

- Sequencer for the thermistor path: periodically triggers the external 8-bit ADC, averages a burst of samples and drives the averaged code onto `v_therm` of the voltage-to-temperature converter.
- Waits out the converter's latency, then registers `temp_therm` as `temp_out` with a one-cycle valid pulse.
- Sits between the ADC interface and the converter; single clock domain.

---
 rtl/therm_sample_ctrl_if.sv | 24 ++
 rtl/therm_sample_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_therm_sample_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/therm_sample_ctrl_if.sv
// rtl/therm_sample_ctrl_if.sv - ADC and converter handshake bundle for therm_sample_ctrl
interface therm_sample_ctrl_if;
  logic       adc_start;
  logic       adc_done;
  logic [7:0] adc_data;
  logic [7:0] v_therm;
  logic [7:0] temp_therm;

  modport master (
    output adc_start,
    input  adc_done,
    input  adc_data,
    output v_therm,
    input  temp_therm
  );

  modport slave (
    input  adc_start,
    output adc_done,
    output adc_data,
    input  v_therm,
    output temp_therm
  );
endinterface

// File: rtl/therm_sample_ctrl.sv
// rtl/therm_sample_ctrl.sv - periodic ADC burst averager feeding the thermistor converter; optional THERM_ALARM_EN hysteresis alarm
module therm_sample_ctrl #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int CONV_LAT      = 1,
  parameter int ADC_TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  therm_sample_ctrl_if.master adc_if,
  output logic [7:0]          temp_out,
  output logic                temp_valid,
  output logic                busy,
  output logic                adc_err,
  output logic                overrun
`ifdef THERM_ALARM_EN
  ,
  input  logic [7:0]          alarm_hi,
  input  logic [7:0]          alarm_lo,
  output logic                alarm
`endif
);
  localparam int TMR_W = $clog2(SAMPLE_PERIOD);
  localparam int TO_W  = $clog2(ADC_TIMEOUT + 1);
  localparam int CL_W  = $clog2(CONV_LAT + 1);
  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ADC_TIMEOUT - 1);
  localparam logic [CL_W-1:0]  CONV_LAST = CL_W'(CONV_LAT - 1);
  localparam logic [CNT_W-1:0] SMP_LAST  = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ADC,
    S_CONVERT,
    S_CAPTURE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [TO_W-1:0]  to_cnt;
  logic [CL_W-1:0]  conv_cnt;
  logic [CNT_W-1:0] smp_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_nxt;
  logic [7:0]       v_therm_q;
  logic             tick;
  logic             last_sample;
  logic             timeout;
  logic             conv_done;
  logic             adc_start_c;
  logic             busy_c;

  // Burst-start timer: free-runs while enabled, parked at zero otherwise
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      tmr <= '0;
    end else if (tmr == TMR_LAST) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  assign tick        = enable && (tmr == TMR_LAST);
  assign sum_nxt     = acc + ACC_W'(adc_if.adc_data);
  assign last_sample = (smp_cnt == SMP_LAST);
  assign timeout     = (to_cnt == TO_LAST);
  assign conv_done   = (conv_cnt == CONV_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: adc_done is tested before timeout so a coincident answer is kept
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (tick) state_nxt = S_START;
      end
      S_START: begin
        state_nxt = S_WAIT_ADC;
      end
      S_WAIT_ADC: begin
        if (adc_if.adc_done) begin
          state_nxt = last_sample ? S_CONVERT : S_START;
        end else if (timeout) begin
          state_nxt = S_IDLE;
        end
      end
      S_CONVERT: begin
        if (conv_done) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    adc_start_c = 1'b0;
    busy_c      = 1'b1;
    case (state)
      S_IDLE:  busy_c      = 1'b0;
      S_START: adc_start_c = 1'b1;
      default: ;
    endcase
  end

  assign adc_if.adc_start = adc_start_c;
  assign adc_if.v_therm   = v_therm_q;
  assign busy             = busy_c;

  // Datapath: accumulate samples, publish the average, capture the converter result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      smp_cnt    <= '0;
      to_cnt     <= '0;
      conv_cnt   <= '0;
      v_therm_q  <= '0;
      temp_out   <= '0;
      temp_valid <= 1'b0;
      adc_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      if (tick && busy_c) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (tick) begin
            acc     <= '0;
            smp_cnt <= '0;
          end
        end
        S_START: begin
          to_cnt <= '0;
        end
        S_WAIT_ADC: begin
          if (adc_if.adc_done) begin
            acc      <= sum_nxt;
            smp_cnt  <= smp_cnt + 1'b1;
            conv_cnt <= '0;
            // Average is ready for the converter from the first CONVERT cycle on
            if (last_sample) v_therm_q <= sum_nxt[ACC_W-1:AVG_LOG2];
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (timeout) adc_err <= 1'b1;
          end
        end
        S_CONVERT: begin
          conv_cnt <= conv_cnt + 1'b1;
        end
        S_CAPTURE: begin
          temp_out   <= adc_if.temp_therm;
          temp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef THERM_ALARM_EN
  // Hysteresis alarm, evaluated only on capture; set wins when thresholds overlap
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm <= 1'b0;
    end else if (state == S_CAPTURE) begin
      if (adc_if.temp_therm >= alarm_hi) begin
        alarm <= 1'b1;
      end else if (adc_if.temp_therm <= alarm_lo) begin
        alarm <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_therm_sample_ctrl.sv
// tb/tb_therm_sample_ctrl.sv - directed and randomized bench for therm_sample_ctrl
module tb_therm_sample_ctrl;
  localparam int P_A = 20;
  localparam int A_A = 2;
  localparam int CL_A = 1;
  localparam int TO_A = 8;
  localparam int P_B = 40;
  localparam int A_B = 4;
  localparam int CL_B = 2;
  localparam int TO_B = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  always #5 clk = ~clk;

  therm_sample_ctrl_if if_a ();
  therm_sample_ctrl_if if_b ();

  logic [7:0] tout_a, tout_b;
  logic       tv_a, tv_b, busy_a, busy_b, err_a, err_b, ovr_a, ovr_b;
`ifdef THERM_ALARM_EN
  logic [7:0] alarm_hi = 8'd80;
  logic [7:0] alarm_lo = 8'd70;
  logic       alarm_a, alarm_b;
  int         exp_alarm = 0;
`endif

  therm_sample_ctrl #(.SAMPLE_PERIOD(P_A), .AVG_LOG2(A_A), .CONV_LAT(CL_A), .ADC_TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .adc_if(if_a.master),
    .temp_out(tout_a), .temp_valid(tv_a), .busy(busy_a), .adc_err(err_a), .overrun(ovr_a)
`ifdef THERM_ALARM_EN
    , .alarm_hi(alarm_hi), .alarm_lo(alarm_lo), .alarm(alarm_a)
`endif
  );

  therm_sample_ctrl #(.SAMPLE_PERIOD(P_B), .AVG_LOG2(A_B), .CONV_LAT(CL_B), .ADC_TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .adc_if(if_b.master),
    .temp_out(tout_b), .temp_valid(tv_b), .busy(busy_b), .adc_err(err_b), .overrun(ovr_b)
`ifdef THERM_ALARM_EN
    , .alarm_hi(alarm_hi), .alarm_lo(alarm_lo), .alarm(alarm_b)
`endif
  );

  // Converter model: output code = input code + 5 (8-bit wrap)
  assign if_a.temp_therm = if_a.v_therm + 8'd5;
  assign if_b.temp_therm = if_b.v_therm + 8'd5;

  int cyc = 0;
  int st_a = 0, vl_a = 0, st_b = 0, vl_b = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (if_a.adc_start === 1'b1) st_a <= st_a + 1;
    if (tv_a === 1'b1) vl_a <= vl_a + 1;
    if (if_b.adc_start === 1'b1) st_b <= st_b + 1;
    if (tv_b === 1'b1) vl_b <= vl_b + 1;
  end

  // ADC models: answer dly cycles after adc_start (0 = never), data from a sample list
  int         dly_a = 3, dly_b = 1;
  logic [7:0] smp_a [256];
  logic [7:0] smp_b [256];
  logic [7:0] rd_a, rd_b;

  initial begin
    int cnt;
    cnt = 0;
    rd_a = 8'd0;
    if_a.adc_done = 1'b0;
    if_a.adc_data = 8'd0;
    forever begin
      @(negedge clk);
      if_a.adc_done = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            if_a.adc_done = 1'b1;
            if_a.adc_data = smp_a[rd_a];
            rd_a = rd_a + 8'd1;
          end
        end
        if (if_a.adc_start === 1'b1 && dly_a > 0) cnt = dly_a;
      end
    end
  end

  initial begin
    int cnt;
    cnt = 0;
    rd_b = 8'd0;
    if_b.adc_done = 1'b0;
    if_b.adc_data = 8'd0;
    forever begin
      @(negedge clk);
      if_b.adc_done = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            if_b.adc_done = 1'b1;
            if_b.adc_data = smp_b[rd_b];
            rd_b = rd_b + 8'd1;
          end
        end
        if (if_b.adc_start === 1'b1 && dly_b > 0) cnt = dly_b;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int bs [4];
  int last_temp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_valid(input int which, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (((which == 0) ? tv_a : tv_b) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Reference: average = floor(sum / 2^AVG_LOG2)
  task automatic load_samples_a(output int ev);
    int sum;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      smp_a[rd_a + 8'(i)] = 8'(bs[i]);
      sum += bs[i];
    end
    ev = sum / (1 << A_A);
  endtask

  task automatic check_capture_a(input string tag, input int ev);
    int et;
    et = (ev + 5) % 256;
    chk({tag, "_vtherm"}, if_a.v_therm, ev);
    chk({tag, "_temp"}, tout_a, et);
    last_temp = et;
`ifdef THERM_ALARM_EN
    if (et >= 80) exp_alarm = 1;
    else if (et <= 70) exp_alarm = 0;
    chk({tag, "_alarm"}, alarm_a, exp_alarm);
`endif
  endtask

  task automatic run_burst_a(input int d, input int tk, input string tag);
    int ev, at;
    wait_until(tk);
    dly_a = d;
    load_samples_a(ev);
    wait_valid(0, 4 * (d + 1) + CL_A + 10, at);
    chk({tag, "_latency"}, at, tk + 4 * (d + 1) + CL_A + 2);
    check_capture_a(tag, ev);
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_adc_start"}, if_a.adc_start, 0);
    chk({tag, "_vtherm"}, if_a.v_therm, 0);
    chk({tag, "_temp_out"}, tout_a, 0);
    chk({tag, "_temp_valid"}, tv_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_adc_err"}, err_a, 0);
    chk({tag, "_overrun"}, ovr_a, 0);
  endtask

  initial begin
    int tk, n0, s0, v0, ev, at, d;
    int alarm_vals [4];
    int alarm_exp [4];

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_a("rst_a");
    chk("rst_b_adc_start", if_b.adc_start, 0);
    chk("rst_b_vtherm", if_b.v_therm, 0);
    chk("rst_b_temp_valid", tv_b, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_flags", {err_b, ovr_b}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic burst: 10,20,30,41 with a 3-cycle ADC
    n0 = cyc;
    en_a = 1'b1;
    s0 = st_a;
    v0 = vl_a;
    bs = '{10, 20, 30, 41};
    tk = n0 + P_A - 1;
    run_burst_a(3, tk, "basic");
    wait_until(tk + P_A);
    chk("basic_starts", st_a - s0, 4);
    chk("basic_valids", vl_a - v0, 1);
    chk("basic_idle_busy", busy_a, 0);
    chk("basic_valid_low", tv_a, 0);

    // Randomized back-to-back bursts
    for (int k = 0; k < 6; k++) begin
      tk += P_A;
      for (int i = 0; i < 4; i++) bs[i] = $urandom_range(0, 255);
      d = $urandom_range(1, 3);
      run_burst_a(d, tk, "rnd");
    end
    chk("rnd_adc_err", err_a, 0);
    chk("rnd_overrun", ovr_a, 0);

    // ADC answering on the timeout cycle; the burst outlasts the period; enable dropped mid-burst
    tk += P_A;
    wait_until(tk);
    dly_a = TO_A;
    for (int i = 0; i < 4; i++) bs[i] = $urandom_range(0, 255);
    load_samples_a(ev);
    s0 = st_a;
    v0 = vl_a;
    wait_until(tk + P_A - 1);
    chk("ovr_before", ovr_a, 0);
    wait_until(tk + P_A + 1);
    chk("ovr_after", ovr_a, 1);
    wait_until(tk + 25);
    en_a = 1'b0;
    wait_valid(0, 40, at);
    chk("slow_latency", at, tk + 4 * (TO_A + 1) + CL_A + 2);
    check_capture_a("slow", ev);
    chk("slow_adc_err", err_a, 0);
    repeat (60) @(negedge clk);
    chk("slow_starts", st_a - s0, 4);
    chk("slow_valids", vl_a - v0, 1);
    chk("disabled_busy", busy_a, 0);

    // Timeout: ADC never answers
    n0 = cyc;
    en_a = 1'b1;
    tk = n0 + P_A - 1;
    wait_until(tk);
    dly_a = 0;
    v0 = vl_a;
    wait_until(tk + 1 + TO_A);
    chk("to_err_pending", err_a, 0);
    wait_until(tk + 2 + TO_A);
    chk("to_err_set", err_a, 1);
    chk("to_idle", busy_a, 0);
    wait_until(tk + P_A - 1);
    chk("to_no_valid", vl_a - v0, 0);
    chk("to_temp_kept", tout_a, last_temp);
    tk += P_A;
    for (int i = 0; i < 4; i++) bs[i] = $urandom_range(0, 255);
    run_burst_a(2, tk, "after_to");
    chk("to_err_sticky", err_a, 1);

    // Reset during the wait for sample 2
    tk += P_A;
    wait_until(tk);
    dly_a = 3;
    for (int i = 0; i < 4; i++) bs[i] = $urandom_range(0, 255);
    load_samples_a(ev);
    wait_until(tk + 6);
    rst = 1'b1;
    @(negedge clk);
    check_reset_a("midrst");
    rst = 1'b0;
    last_temp = 0;
`ifdef THERM_ALARM_EN
    exp_alarm = 0;
`endif
    v0 = vl_a;
    wait_until(tk + 7 + P_A - 2);
    chk("midrst_no_valid", vl_a - v0, 0);
    chk("midrst_idle", busy_a, 0);
    tk = tk + 7 + P_A - 1;
    bs = '{3, 9, 12, 8};
    run_burst_a(1, tk, "post_rst");

`ifdef THERM_ALARM_EN
    // Hysteresis: temperatures 75, 82, 75, 69
    alarm_vals = '{70, 77, 70, 64};
    alarm_exp = '{0, 1, 1, 0};
    for (int k = 0; k < 4; k++) begin
      tk += P_A;
      for (int i = 0; i < 4; i++) bs[i] = alarm_vals[k];
      run_burst_a(1, tk, "alarm_seq");
      chk("alarm_list", alarm_a, alarm_exp[k]);
    end
`else
    alarm_vals = '{0, 0, 0, 0};
    alarm_exp = alarm_vals;
`endif

    // Sixteen-sample bursts: full-scale and truncation
    en_a = 1'b0;
    for (int i = 0; i < 16; i++) smp_b[i] = 8'd255;
    for (int i = 16; i < 31; i++) smp_b[i] = 8'd0;
    smp_b[31] = 8'd15;
    dly_b = 1;
    @(negedge clk);
    n0 = cyc;
    en_b = 1'b1;
    wait_valid(1, P_B + 60, at);
    chk("wide_latency", at, n0 + P_B - 1 + 16 * 2 + CL_B + 2);
    chk("wide_vtherm", if_b.v_therm, 255);
    chk("wide_temp", tout_b, 4);
    wait_valid(1, P_B + 10, at);
    chk("trunc_latency", at, n0 + 2 * P_B - 1 + 16 * 2 + CL_B + 2);
    chk("trunc_vtherm", if_b.v_therm, 0);
    chk("trunc_temp", tout_b, 5);
    chk("wide_flags", {err_b, ovr_b}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
